// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared state encoding, port indices and counter width for sram_arbiter
package sram_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_VIDEO = 1'b1;
  localparam int WAIT_W = 3;
endpackage

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port round-robin arbiter and wait-state sequencer for an async 8-bit SRAM.
// Define SRAM_ARB_VIDEO_PRIORITY_EN to make port 1 (video) win every tie.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [7:0]        wdata0,
  input  logic [7:0]        wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [7:0]        rdata0,
  output logic [7:0]        rdata1,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [7:0]        sram_dq_i,
  output logic [7:0]        sram_dq_o,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);
  state_t              r_state, w_next;
  logic                r_last, r_port, r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [7:0]          r_wdata, r_rdata0, r_rdata1;
  logic [WAIT_W-1:0]   r_cnt;
  logic                w_req, w_grant, w_access, w_last_cyc;
  assign w_req = req0 | req1;
`ifdef SRAM_ARB_VIDEO_PRIORITY_EN
  assign w_grant = req1 ? PORT_VIDEO : PORT_CPU;
`else
  assign w_grant = (req0 && req1) ? ~r_last : (req1 ? PORT_VIDEO : PORT_CPU);
`endif
  assign w_access = r_state == ACCESS;
  assign w_last_cyc = r_cnt == '0;
  always_comb begin
    w_next = IDLE;
    if (r_state == IDLE) w_next = w_req ? ACCESS : IDLE;
    else if (r_state == ACCESS) w_next = w_last_cyc ? DONE : ACCESS;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_last   <= PORT_VIDEO;
      r_port   <= PORT_CPU;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_req) begin
        r_port  <= w_grant;
        r_last  <= w_grant;
        r_we    <= w_grant ? we1 : we0;
        r_addr  <= w_grant ? addr1 : addr0;
        r_wdata <= w_grant ? wdata1 : wdata0;
        r_cnt   <= WAIT_W'(WAIT_CYCLES);
      end
      if (w_access) begin
        r_cnt <= r_cnt - 1'b1;
        if (w_last_cyc && !r_we && r_port == PORT_CPU) r_rdata0 <= sram_dq_i;
        if (w_last_cyc && !r_we && r_port == PORT_VIDEO) r_rdata1 <= sram_dq_i;
      end
    end
  end
  // The last write cycle releases we_n while data is still driven, giving hold time.
  assign sram_we_n  = ~(w_access && r_we && (!w_last_cyc || WAIT_CYCLES == 0));
  assign sram_ce_n  = ~w_access;
  assign sram_oe_n  = ~(w_access && !r_we);
  assign sram_dq_oe = w_access && r_we;
  assign sram_dq_o  = r_wdata;
  assign sram_addr  = r_addr;
  assign ack0       = r_state == DONE && r_port == PORT_CPU;
  assign ack1       = r_state == DONE && r_port == PORT_VIDEO;
  assign rdata0     = r_rdata0;
  assign rdata1     = r_rdata1;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed vector bench for sram_arbiter (WAIT_CYCLES=1 and WAIT_CYCLES=0 instances)
module tb_sram_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [15:0] addr0 = 0, addr1 = 0;
  logic [7:0] wdata0 = 0, wdata1 = 0;
  logic ack0, ack1, s_oe, ce_n, oe_n, we_n;
  logic [7:0] rdata0, rdata1, s_dqi, s_dqo;
  logic [15:0] s_addr;

  logic b_req0 = 0, b_req1 = 0, b_we0 = 0, b_we1 = 0;
  logic [15:0] b_addr0 = 0, b_addr1 = 0;
  logic [7:0] b_wdata0 = 0, b_wdata1 = 0;
  logic b_ack0, b_ack1, b_s_oe, b_ce_n, b_oe_n, b_we_n;
  logic [7:0] b_rdata0, b_rdata1, b_s_dqi, b_s_dqo;
  logic [15:0] b_s_addr;

  sram_arbiter #(.ADDR_W(16), .WAIT_CYCLES(1)) u_a (
    .clk(clk), .reset_n(reset_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .sram_addr(s_addr), .sram_dq_i(s_dqi), .sram_dq_o(s_dqo), .sram_dq_oe(s_oe),
    .sram_ce_n(ce_n), .sram_oe_n(oe_n), .sram_we_n(we_n));

  sram_arbiter #(.ADDR_W(16), .WAIT_CYCLES(0)) u_b (
    .clk(clk), .reset_n(reset_n), .req0(b_req0), .req1(b_req1), .we0(b_we0), .we1(b_we1),
    .addr0(b_addr0), .addr1(b_addr1), .wdata0(b_wdata0), .wdata1(b_wdata1),
    .ack0(b_ack0), .ack1(b_ack1), .rdata0(b_rdata0), .rdata1(b_rdata1),
    .sram_addr(b_s_addr), .sram_dq_i(b_s_dqi), .sram_dq_o(b_s_dqo), .sram_dq_oe(b_s_oe),
    .sram_ce_n(b_ce_n), .sram_oe_n(b_oe_n), .sram_we_n(b_we_n));

  // SRAM models: async read, write captured while ce/we low and the pad is driven
  logic [7:0] mem_a [0:65535];
  logic [7:0] mem_b [0:65535];
  assign s_dqi = (!ce_n && !oe_n) ? mem_a[s_addr] : 8'h00;
  assign b_s_dqi = (!b_ce_n && !b_oe_n) ? mem_b[b_s_addr] : 8'h00;
  always @(posedge clk) begin
    if (!reset_n) mem_a[16'h1234] <= 8'h5A;
    else if (!ce_n && !we_n && s_oe) mem_a[s_addr] <= s_dqo;
    if (!b_ce_n && !b_we_n && b_s_oe) mem_b[b_s_addr] <= b_s_dqo;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  logic pa0 = 0, pa1 = 0, pb0 = 0;
  always @(negedge clk) begin
    check("ack_exclusive", {31'b0, ack0 & ack1}, 0);
    check("ack_width", {30'b0, pa0 & ack0, pa1 & ack1}, 0);
    check("b_ack_width", {31'b0, pb0 & b_ack0}, 0);
    pa0 <= ack0;
    pa1 <= ack1;
    pb0 <= b_ack0;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // One access; called at posedge+1, returns at posedge+1 after the ack cycle
  task automatic do_acc(input int d, input logic p, input logic w, input logic [15:0] a,
                        input logic [7:0] wd, output int cyc, output int n_oe,
                        output int n_we, output int n_dq, output int oth);
    logic am, ao;
    if (d == 0 && !p) begin req0 = 1; we0 = w; addr0 = a; wdata0 = wd; end
    if (d == 0 && p) begin req1 = 1; we1 = w; addr1 = a; wdata1 = wd; end
    if (d == 1) begin b_req0 = 1; b_we0 = w; b_addr0 = a; b_wdata0 = wd; end
    cyc = 0; n_oe = 0; n_we = 0; n_dq = 0; oth = 0;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      am = (d == 1) ? b_ack0 : (p ? ack1 : ack0);
      ao = (d == 1) ? b_ack1 : (p ? ack0 : ack1);
      if (((d == 1) ? b_oe_n : oe_n) == 1'b0) n_oe++;
      if (((d == 1) ? b_we_n : we_n) == 1'b0) n_we++;
      if (((d == 1) ? b_s_oe : s_oe) == 1'b1) n_dq++;
      if (ao) oth++;
      if (am) break;
    end
    @(posedge clk);
    #1;
    if (d == 0 && !p) req0 = 0;
    if (d == 0 && p) req1 = 0;
    if (d == 1) b_req0 = 0;
  endtask

  typedef struct {
    logic p;
    logic w;
    logic [15:0] a;
    logic [7:0] d;
    logic [7:0] rd;
    int e_oe;
    int e_we;
    int e_dq;
  } vec_t;

  vec_t v[8];
  int cyc, no, nw, nd, ot, k, t, tl;
  logic [7:0] m0, m1;
  logic g;

  initial begin
    v[0] = '{1'b0, 1'b0, 16'h1234, 8'h00, 8'h5A, 2, 0, 0};
    v[1] = '{1'b1, 1'b1, 16'h0100, 8'hC3, 8'h00, 0, 1, 2};
    v[2] = '{1'b1, 1'b0, 16'h0100, 8'h00, 8'hC3, 2, 0, 0};
    v[3] = '{1'b0, 1'b1, 16'h0100, 8'h77, 8'h00, 0, 1, 2};
    v[4] = '{1'b1, 1'b0, 16'h0100, 8'h00, 8'h77, 2, 0, 0};
    v[5] = '{1'b0, 1'b0, 16'h0100, 8'h00, 8'h77, 2, 0, 0};
    v[6] = '{1'b0, 1'b1, 16'hFFFF, 8'h01, 8'h00, 0, 1, 2};
    v[7] = '{1'b0, 1'b0, 16'hFFFF, 8'h00, 8'h01, 2, 0, 0};

    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    @(negedge clk);
    check("rst_ce_n", ce_n, 1);
    check("rst_oe_n", oe_n, 1);
    check("rst_we_n", we_n, 1);
    check("rst_dq_oe", s_oe, 0);
    check("rst_addr", s_addr, 0);
    check("rst_dq_o", s_dqo, 0);
    check("rst_acks", {ack0, ack1}, 0);
    check("rst_rdata", {rdata0, rdata1}, 0);
    @(posedge clk);
    #1;

    m0 = 0; m1 = 0;
    for (int i = 0; i < 8; i++) begin
      do_acc(0, v[i].p, v[i].w, v[i].a, v[i].d, cyc, no, nw, nd, ot);
      if (!v[i].w && !v[i].p) m0 = v[i].rd;
      if (!v[i].w && v[i].p) m1 = v[i].rd;
      check($sformatf("v%0d_latency", i), cyc, 4);
      check($sformatf("v%0d_oe_cycles", i), no, v[i].e_oe);
      check($sformatf("v%0d_we_cycles", i), nw, v[i].e_we);
      check($sformatf("v%0d_dqoe_cycles", i), nd, v[i].e_dq);
      check($sformatf("v%0d_other_ack", i), ot, 0);
      check($sformatf("v%0d_rdata0", i), rdata0, m0);
      check($sformatf("v%0d_rdata1", i), rdata1, m1);
    end

    // Both ports requesting continuously after reset
    reset_n = 0;
    @(posedge clk);
    #1 reset_n = 1;
    req0 = 1; we0 = 0; addr0 = 16'h1234;
    req1 = 1; we1 = 0; addr1 = 16'h0100;
    k = 0; t = 0; tl = 0;
    while (k < 6 && t < 80) begin
      @(negedge clk);
      t++;
      if (ack0 || ack1) begin
        g = ack1;
`ifdef SRAM_ARB_VIDEO_PRIORITY_EN
        check($sformatf("tie_grant%0d", k), g, 1);
`else
        check($sformatf("tie_grant%0d", k), g, k[0]);
`endif
        if (k > 0) check($sformatf("tie_gap%0d", k), t - tl, 4);
        tl = t;
        k++;
      end
    end
    check("tie_count", k, 6);
    @(posedge clk);
    #1 req0 = 0; req1 = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset during the strobe of a write
    req0 = 1; we0 = 1; addr0 = 16'h2000; wdata0 = 8'hEE;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_mid_we_low", we_n, 0);
    reset_n = 0; req0 = 0; we0 = 0;
    @(negedge clk);
    check("rst_mid_strobes", {ce_n, oe_n, we_n}, 3'b111);
    check("rst_mid_dq_oe", s_oe, 0);
    check("rst_mid_acks", {ack0, ack1}, 0);
    check("rst_mid_addr", s_addr, 0);
    @(posedge clk);
    #1 reset_n = 1;
    do_acc(0, 1'b0, 1'b0, 16'h1234, 8'h00, cyc, no, nw, nd, ot);
    check("post_rst_latency", cyc, 4);
    check("post_rst_rdata0", rdata0, 8'h5A);
    check("post_rst_rdata1", rdata1, 8'h00);

    // Zero wait states
    do_acc(1, 1'b0, 1'b1, 16'hFFFF, 8'h11, cyc, no, nw, nd, ot);
    check("w0_wr_latency", cyc, 3);
    check("w0_wr_we_cycles", nw, 1);
    check("w0_wr_dqoe_cycles", nd, 1);
    do_acc(1, 1'b0, 1'b0, 16'hFFFF, 8'h00, cyc, no, nw, nd, ot);
    check("w0_rd_latency", cyc, 3);
    check("w0_rd_oe_cycles", no, 1);
    check("w0_rd_rdata0", b_rdata0, 8'h11);
    check("w0_other_ack", ot, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
